// File: rtl/line_steer_ctrl.sv
// line_steer_ctrl: line-follower steering controller.
// Synchronises and debounces a row of line sensors, forms a signed weighted
// position error and drives a servo direction through a HOLD/TRACK/LOST/STOP FSM.
// Optional feature macro: LOST_SEARCH_EN (LOST steers toward last seen side).
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous reset, active-high
//   sensor          asynchronous sensor bits, 1 = line (bit 0 rightmost)
//   sw              hold request, 1 = rest
//   servo_direction 00 REST, 01 LEFT, 10 STRAIGHT, 11 RIGHT (registered)
//   steer_mag       |error| (registered)
//   line_lost       high in LOST and STOP (registered)
//   state           FSM state: 00 HOLD, 01 TRACK, 10 LOST, 11 STOP
module line_steer_ctrl #(
  parameter int unsigned N_SENSORS    = 5,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned LOST_TIMEOUT = 1000,
  parameter int unsigned DEADBAND     = 0,
  localparam int unsigned ERR_W       = $clog2(N_SENSORS * N_SENSORS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SENSORS-1:0] sensor,
  input  logic                 sw,
  output logic [1:0]           servo_direction,
  output logic [ERR_W-2:0]     steer_mag,
  output logic                 line_lost,
  output logic [1:0]           state
);

  localparam int unsigned MAG_W = ERR_W - 1;
  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);
  localparam int unsigned TMR_W = $clog2(LOST_TIMEOUT + 1);
  localparam logic signed [ERR_W-1:0] DB_POS = ERR_W'(DEADBAND);
  localparam logic signed [ERR_W-1:0] DB_NEG = -DB_POS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(LOST_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_HOLD  = 2'b00,
    S_TRACK = 2'b01,
    S_LOST  = 2'b10,
    S_STOP  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    DIR_REST     = 2'b00,
    DIR_LEFT     = 2'b01,
    DIR_STRAIGHT = 2'b10,
    DIR_RIGHT    = 2'b11
  } dir_t;

  logic [N_SENSORS-1:0] sync1;
  logic [N_SENSORS-1:0] sync2;
  logic [N_SENSORS-1:0] filt;
  logic [CNT_W-1:0]     cnt [N_SENSORS];
  logic [TMR_W-1:0]     tmr;

  state_t state_q;
  state_t next_state;
  dir_t   dir_d;
  dir_t   track_dir;
  logic [MAG_W-1:0] mag_d;
  logic [MAG_W-1:0] mag_abs;
  logic             lost_d;
  logic signed [ERR_W-1:0] err;
  logic             any_line;

  // Two-flop synchroniser on every sensor bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: filtered bit flips on the FILTER_LEN-th consecutive differing cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < int'(N_SENSORS); i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_SENSORS); i++) begin
        if (sync2[i] != filt[i]) begin
          if (cnt[i] == CNT_LAST) begin
            filt[i] <= sync2[i];
            cnt[i]  <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Weighted position error, w(i) = 2i-(N-1); positive means line is to the left
  always_comb begin
    err = '0;
    for (int i = 0; i < int'(N_SENSORS); i++) begin
      if (filt[i]) err = err + $signed(ERR_W'(2 * i - (int'(N_SENSORS) - 1)));
    end
  end

  assign any_line = |filt;
  assign mag_abs  = err[ERR_W-1] ? MAG_W'(-err) : MAG_W'(err);

`ifdef LOST_SEARCH_EN
  dir_t last_dir;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_HOLD;
    else     state_q <= next_state;
  end

  // Next state and next output values; outputs reflect the state being entered
  always_comb begin
    next_state = state_q;
    dir_d      = DIR_REST;
    mag_d      = '0;
    lost_d     = 1'b0;
    track_dir  = DIR_STRAIGHT;

    if (err > DB_POS)      track_dir = DIR_LEFT;
    else if (err < DB_NEG) track_dir = DIR_RIGHT;

    unique case (state_q)
      S_HOLD:  next_state = any_line ? S_TRACK : S_LOST;
      S_TRACK: if (!any_line) next_state = S_LOST;
      // Line return wins over a simultaneous timeout
      S_LOST: begin
        if (any_line)             next_state = S_TRACK;
        else if (tmr == TMR_LAST) next_state = S_STOP;
      end
      S_STOP:  next_state = S_STOP;
      default: next_state = S_HOLD;
    endcase

    if (sw) next_state = S_HOLD;

    unique case (next_state)
      S_TRACK: begin
        dir_d = track_dir;
        mag_d = mag_abs;
      end
      S_LOST: begin
        lost_d = 1'b1;
        mag_d  = steer_mag;
`ifdef LOST_SEARCH_EN
        dir_d  = last_dir;
`else
        dir_d  = DIR_REST;
`endif
      end
      S_STOP:  lost_d = 1'b1;
      default: ;
    endcase
  end

  // Lost timer counts only while remaining in LOST; cleared everywhere else
  always_ff @(posedge clk) begin
    if (rst)                                          tmr <= '0;
    else if (state_q == S_LOST && next_state == S_LOST) tmr <= tmr + 1'b1;
    else                                              tmr <= '0;
  end

`ifdef LOST_SEARCH_EN
  // Remember the last side actually steered toward while tracking
  always_ff @(posedge clk) begin
    if (rst)
      last_dir <= DIR_LEFT;
    else if (next_state == S_TRACK && track_dir != DIR_STRAIGHT)
      last_dir <= track_dir;
  end
`endif

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      servo_direction <= DIR_REST;
      steer_mag       <= '0;
      line_lost       <= 1'b0;
    end else begin
      servo_direction <= dir_d;
      steer_mag       <= mag_d;
      line_lost       <= lost_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Directed bench for line_steer_ctrl with N_SENSORS=5, FILTER_LEN=4,
// LOST_TIMEOUT=16, DEADBAND=0. Inputs change on the falling edge, outputs
// are sampled on the falling edge.
module tb_line_steer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] sensor;
  logic       sw;
  logic [1:0] servo_direction;
  logic [4:0] steer_mag;
  logic       line_lost;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

`ifdef LOST_SEARCH_EN
  localparam logic [1:0] LOST_DIR = 2'b01;
`else
  localparam logic [1:0] LOST_DIR = 2'b00;
`endif

  line_steer_ctrl #(
    .N_SENSORS    (5),
    .FILTER_LEN   (4),
    .LOST_TIMEOUT (16),
    .DEADBAND     (0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .sensor          (sensor),
    .sw              (sw),
    .servo_direction (servo_direction),
    .steer_mag       (steer_mag),
    .line_lost       (line_lost),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] dir,
                           input logic [4:0] mag, input logic lost);
    check({tag, "_state"}, 8'(state), 8'(st));
    check({tag, "_dir"},   8'(servo_direction), 8'(dir));
    check({tag, "_mag"},   8'(steer_mag), 8'(mag));
    check({tag, "_lost"},  8'(line_lost), 8'(lost));
  endtask

  initial begin
    rst    = 1'b1;
    sensor = 5'b00000;
    sw     = 1'b0;
    @(negedge clk);
    tick(2);
    check_all("reset", 2'b00, 2'b00, 5'd0, 1'b0);

    // Centred line: visible on edge 7, not before
    rst    = 1'b0;
    sensor = 5'b00100;
    tick(6);
    check("center_e6_state", 8'(state), 8'(2'b10));
    tick(1);
    check_all("center_e7", 2'b01, 2'b10, 5'd0, 1'b0);

    // Line on the far left
    sensor = 5'b10000;
    tick(6);
    check("left_e6_dir", 8'(servo_direction), 8'(2'b10));
    tick(1);
    check_all("left_e7", 2'b01, 2'b01, 5'd4, 1'b0);

    // Line on the two rightmost sensors: -4 + -2 = -6
    sensor = 5'b00011;
    tick(7);
    check_all("right", 2'b01, 2'b11, 5'd6, 1'b0);

    // Three-cycle glitch must be rejected by the debounce
    sensor = 5'b00100;
    tick(7);
    check("glitch_pre_dir", 8'(servo_direction), 8'(2'b10));
    sensor = 5'b10000;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) sensor = 5'b00100;
      tick(1);
      check($sformatf("glitch_c%0d_dir", k), 8'(servo_direction), 8'(2'b10));
    end

    // Line loss and timeout
    sensor = 5'b10000;
    tick(7);
    check_all("pre_lost", 2'b01, 2'b01, 5'd4, 1'b0);
    sensor = 5'b00000;
    tick(6);
    check("lost_e6_state", 8'(state), 8'(2'b01));
    tick(1);
    check_all("lost_entry", 2'b10, LOST_DIR, 5'd4, 1'b1);
    tick(15);
    check_all("lost_t15", 2'b10, LOST_DIR, 5'd4, 1'b1);
    tick(1);
    check_all("stop", 2'b11, 2'b00, 5'd0, 1'b1);

    // STOP ignores the line; only sw releases it
    sensor = 5'b00100;
    tick(10);
    check_all("stop_line", 2'b11, 2'b00, 5'd0, 1'b1);
    sw = 1'b1;
    tick(1);
    check_all("sw_hold", 2'b00, 2'b00, 5'd0, 1'b0);
    sw = 1'b0;
    tick(1);
    check_all("hold_track", 2'b01, 2'b10, 5'd0, 1'b0);

    // Reset in the middle of LOST discards the timer
    sensor = 5'b00000;
    tick(7);
    check("lost2_state", 8'(state), 8'(2'b10));
    tick(10);
    rst = 1'b1;
    sw  = 1'b1;
    tick(1);
    check_all("mid_rst", 2'b00, 2'b00, 5'd0, 1'b0);
    rst = 1'b0;
    sw  = 1'b0;
    tick(1);
    check_all("post_rst_lost", 2'b10, LOST_DIR, 5'd0, 1'b1);
    tick(15);
    check("post_rst_t15_state", 8'(state), 8'(2'b10));
    tick(1);
    check_all("post_rst_stop", 2'b11, 2'b00, 5'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
